seq_test_controller: RTL
========================

# seq_test_controller

Run controller for the board-level exercising of a single-input synchronous sequential circuit (state register plus next-state/output logic, serial input `x`, output `z`). It drives the circuit's serial input, issues its state-advance enables and clear, captures one `z` sample per step into a log, and reports pass/fail against an expected response. It sits between the switch/button front end and the circuit under test. It runs in auto mode (fixed step rate) or single-step mode (button per step).

## Interface
Parameters:
- `LEN`, default 8: number of steps per run; width of pattern and log.
- `DIV`, default 50_000_000: clock cycles per step in auto mode (≥2); benches use 4.

Ports:
- `cp`  in  1  system clock; all state on rising edge.
- `rd`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- `mode`  in  1  0 = auto, 1 = single-step; sampled with `start`.
- `step_btn`  in  1  one-cycle pulse; advances one step in single-step mode.
- `pattern`  in  LEN  input bits for `x`; bit 0 applied first; sampled with `start`.
- `expect`  in  LEN  expected `z` log; sampled with `start`.
- `z`  in  1  output of circuit under test.
- `x`  out  1  serial input to circuit under test.
- `dut_en`  out  1  one-cycle state-advance enable to circuit under test.
- `dut_clr`  out  1  clear request to circuit under test, active-high.
- `z_log`  out  LEN  captured `z`; bit i = step i.
- `step_idx`  out  $clog2(LEN)  current step.
- `busy`, `done`, `pass`  out  1 each  run status.

## Operation
States:
- IDLE: `dut_clr`=1. `start` → CLEAR. Latch `mode`, `pattern`, `expect`.
- CLEAR: one cycle. `dut_clr`=1, `z_log`←0, `step_idx`←0, `done`/`pass`←0 → APPLY.
- APPLY: `x` = pattern_r[`step_idx`]. Advance condition:
  - auto: tick counter reaches DIV-1;
  - step mode: `step_btn`.
  - On advance → ADVANCE.
- ADVANCE: one cycle. `z_log[step_idx]` ← `z` (Mealy sample before state update). `dut_en`=1.
  - If `step_idx`==LEN-1 → CHECK.
  - Else `step_idx`+1 → APPLY.
- CHECK: one cycle. `pass` ← (`z_log`==expect_r) → DONE.
- DONE: `done`=1. Hold `z_log`/`pass`. `start` → CLEAR.

Rules:
- `busy`=1 in CLEAR/APPLY/ADVANCE/CHECK.
- `start` is ignored while busy.
- `step_btn` is ignored outside APPLY and in auto mode.
- `start` and `step_btn` together in IDLE/DONE: `start` wins.
- Tick counter clears on every APPLY entry, so each step has exactly DIV cycles of APPLY.
- `step_idx` never wraps past LEN-1.
- `x`=0 outside APPLY/ADVANCE. `x` is stable through ADVANCE.

## Timing
- Reset (async, any state, mid-run included) → IDLE:
  - `x`=0, `dut_en`=0, `dut_clr`=1;
  - `z_log`=0, `step_idx`=0, `busy`=0, `done`=0, `pass`=0.
  - The run is abandoned.
- Edge 0 samples `start` → CLEAR after edge 0, APPLY after edge 1.
- Auto mode: each step lasts DIV+1 cycles (DIV APPLY + 1 ADVANCE). `done` rises at edge LEN·(DIV+1)+2. LEN=8, DIV=4: edge 42.
- Single-step: ADVANCE follows the edge sampling `step_btn`. `dut_en` is high exactly that cycle.
- `dut_en` never high in consecutive cycles and never high together with `dut_clr`.
- All outputs are registered or decoded from state only. There is no combinational path from `z`, `start` or `step_btn` to outputs.

## Structure
- Shared package `seq_ctrl_pkg`: state enum (IDLE, CLEAR, APPLY, ADVANCE, CHECK, DONE) and mode constants (AUTO=0, STEP=1).
- Sub-module `seq_tick_gen`: DIV-cycle counter with synchronous clear and enable, producing a one-cycle tick. Instantiated once; clear driven on APPLY entry.
- Controller FSM, pattern/expect latches and log register live in the top.

## Test plan
Bench model for the circuit under test: `y` cleared by `dut_clr`, `y`←`x` on `dut_en`, `z`=`x`&`y`.
- Auto run, LEN=8, DIV=4, `pattern`=8'h6D, `expect`=8'h48, `start` at edge 0 → `z_log`=8'h48, `pass`=1, `done` rises at edge 42, exactly 8 `dut_en` pulses.
- Same run with `expect`=8'h49 → `done`=1, `pass`=0, `z_log`=8'h48.
- Single-step, `pattern`=8'hFF → no `dut_en` without `step_btn`. After 8 pulses: `z_log`=8'hFE, `done`=1. A 9th `step_btn` in DONE has no effect.
- `rd` asserted during step 3 of an auto run → all outputs immediately at reset values. A new `start` completes a full correct run.
- `start` pulsed again during step 5 → ignored: total cycle count and `z_log` unchanged. `start` in DONE → new run with `z_log` cleared in CLEAR.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared controller state enum and run-mode constants
package seq_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, APPLY, ADVANCE, CHECK, DONE} state_t;
  localparam logic AUTO = 1'b0;
  localparam logic STEP = 1'b1;
endpackage

// File: rtl/seq_tick_gen.sv
// seq_tick_gen: DIV-cycle counter with sync clear and enable, one-cycle tick on the last count
module seq_tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  // count enabled cycles, wrapping after the tick; clear restarts the period
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/seq_test_controller.sv
// seq_test_controller: runs a serial pattern through a sequential circuit and logs/checks its z response
module seq_test_controller import seq_ctrl_pkg::*; #(
  parameter int LEN = 8,
  parameter int DIV = 50_000_000
) (
  input  logic                    cp,
  input  logic                    rd,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    step_btn,
  input  logic [LEN-1:0]          pattern,
  input  logic [LEN-1:0]          expected,
  input  logic                    z,
  output logic                    x,
  output logic                    dut_en,
  output logic                    dut_clr,
  output logic [LEN-1:0]          z_log,
  output logic [$clog2(LEN)-1:0]  step_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    pass
);
  localparam int IW = $clog2(LEN);
  state_t state, state_n;
  logic mode_r, tick, last, launch;
  logic [LEN-1:0] pattern_r, expect_r;
  assign last = step_idx == IW'(LEN - 1);
  assign launch = (state == IDLE || state == DONE) && start;
  // the tick counter restarts whenever APPLY is about to be entered
  seq_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (cp),
    .rst  (rd),
    .clr  (state == CLEAR || state == ADVANCE),
    .en   (state == APPLY && mode_r == AUTO),
    .tick (tick)
  );
  // state register
  always_ff @(posedge cp or posedge rd)
    if (rd) state <= IDLE;
    else state <= state_n;
  // next state and state-decoded outputs
  always_comb begin
    state_n = state;
    x       = 1'b0;
    dut_en  = 1'b0;
    dut_clr = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        dut_clr = 1'b1;
        state_n = start ? CLEAR : IDLE;
      end
      CLEAR: begin
        dut_clr = 1'b1;
        state_n = APPLY;
      end
      APPLY: begin
        x       = pattern_r[step_idx];
        state_n = (mode_r == STEP ? step_btn : tick) ? ADVANCE : APPLY;
      end
      ADVANCE: begin
        x       = pattern_r[step_idx];
        dut_en  = 1'b1;
        state_n = last ? CHECK : APPLY;
      end
      CHECK: state_n = DONE;
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_n = start ? CLEAR : DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  // run latches, z capture, step index and verdict; cleared as the run launches so CLEAR shows a fresh log
  always_ff @(posedge cp or posedge rd)
    if (rd) begin
      mode_r    <= AUTO;
      pattern_r <= '0;
      expect_r  <= '0;
      z_log     <= '0;
      step_idx  <= '0;
      pass      <= 1'b0;
    end else begin
      if (launch) begin
        mode_r    <= mode;
        pattern_r <= pattern;
        expect_r  <= expected;
        z_log     <= '0;
        step_idx  <= '0;
        pass      <= 1'b0;
      end
      if (state == ADVANCE) begin
        z_log[step_idx] <= z;
        if (!last) step_idx <= step_idx + IW'(1);
      end
      if (state == CHECK) pass <= z_log == expect_r;
    end
endmodule
